rv_egress_fifo: RTL and testbench

// - Transmit-side end of the ready/valid channel: buffers words from a simple

---
 rtl/rv_egress_fifo.sv | 97 +++++++++
 tb/tb_rv_egress_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_egress_fifo.sv
// rv_egress_fifo: transmit-side end of a ready/valid channel.
// Words arrive on a push port that has no handshake and leave through a
// valid/ready egress port. The egress head is held steady until it is
// accepted. Pushes that arrive while the FIFO is full are dropped.
// Optional feature macro: RV_EGRESS_DROP_CNT_EN enables the saturating
// dropped-push counter on drop_cnt. Without the macro, drop_cnt is tied to 0.
module rv_egress_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       egress_valid,
    input  logic                       egress_ready,
    output logic [DATA_W-1:0]          egress_data,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [LVL_W-1:0]  level_next;
    logic              push;
    logic              pop;

    // Push is judged against the registered full flag, so a pop in the same
    // cycle never makes room for that push. Pop is a completed transfer.
    assign push = wr_en && !full;
    assign pop  = egress_valid && egress_ready;

    // The head is the word at the read pointer. Valid depends only on the
    // registered level, so it never follows egress_ready combinationally.
    assign egress_valid = (level != '0);
    assign egress_data  = mem[rd_ptr];

    // The occupancy change for this cycle. A simultaneous push and pop
    // cancel out, and the pushed word queues behind the head.
    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    // Pointers, level and registered full flag. The pointers wrap silently.
    // Full and empty are derived from level, not from pointer comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next;
            full  <= (level_next == LVL_W'(DEPTH));
        end
    end

    // The storage array has no reset. Its words are don't-care until the
    // level marks them as valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef RV_EGRESS_DROP_CNT_EN
    // Counts every cycle that presents a push while the FIFO is full.
    // The counter saturates at its maximum value and only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (wr_en && full && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_egress_fifo.sv
// tb_rv_egress_fifo: scoreboard bench for rv_egress_fifo.
// A reference model runs on each rising edge. It queues the words it expects
// the FIFO to accept, and it pops a word on each expected transfer.
// A monitor on the falling edge compares the DUT outputs against the model.
// Directed sections also compare the DUT outputs against hand-computed
// constants.
module tb_rv_egress_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int LVL_W  = $clog2(DEPTH+1);
`ifdef RV_EGRESS_DROP_CNT_EN
    localparam int DROP_ON = 1;
`else
    localparam int DROP_ON = 0;
`endif

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic [LVL_W-1:0]  level;
    logic              egress_valid;
    logic              egress_ready;
    logic [DATA_W-1:0] egress_data;
    logic [CNT_W-1:0]  drop_cnt;

    int num_compared = 0;
    int num_failed   = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                drop_model = 0;
    logic              model_started = 1'b0;
    logic              prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_head = '0;

    rv_egress_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .level       (level),
        .egress_valid(egress_valid),
        .egress_ready(egress_ready),
        .egress_data (egress_data),
        .drop_cnt    (drop_cnt)
    );

    // 10-unit clock period. The first rising edge is at time 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the next rising edge consume them, and
    // return 1 time unit after that edge so that outputs can be sampled.
    task automatic applyStimulus(input logic r, input logic w,
                                 input logic [DATA_W-1:0] d, input logic rdy);
        rst          = r;
        wr_en        = w;
        wr_data      = d;
        egress_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Reference model. It sees the same inputs as the DUT at each edge.
    // A push is accepted only if the FIFO was not full at the start of the
    // cycle. A pop happens whenever a word is held and ready is high.
    always @(posedge clk) begin
        model_started <= 1'b1;
        if (rst) begin
            exp_q.delete();
            drop_model <= 0;
        end else begin
            if (DROP_ON != 0 && wr_en && exp_q.size() == DEPTH &&
                drop_model != (1 << CNT_W) - 1) begin
                drop_model <= drop_model + 1;
            end
            if (exp_q.size() == DEPTH) begin
                if (egress_ready) void'(exp_q.pop_front());
            end else begin
                if (exp_q.size() != 0 && egress_ready) void'(exp_q.pop_front());
                if (wr_en) exp_q.push_back(wr_data);
            end
        end
    end

    // Monitor. On every falling edge it compares all DUT outputs with the
    // model, and it checks that a stalled head stays valid and unchanged.
    always @(negedge clk) begin
        if (model_started) begin
            checkOutput("mon_valid", {31'd0, egress_valid}, {31'd0, exp_q.size() != 0});
            checkOutput("mon_level", {{(32-LVL_W){1'b0}}, level}, exp_q.size());
            checkOutput("mon_full", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
            checkOutput("mon_drop_cnt", {16'd0, drop_cnt}, drop_model);
            if (exp_q.size() != 0) begin
                checkOutput("mon_data", {24'd0, egress_data}, {24'd0, exp_q[0]});
            end
            if (prev_hold) begin
                checkOutput("hold_valid", {31'd0, egress_valid}, 32'd1);
                checkOutput("hold_data", {24'd0, egress_data}, {24'd0, prev_head});
            end
            prev_hold <= (exp_q.size() != 0) && !egress_ready && !rst;
            prev_head <= (exp_q.size() != 0) ? exp_q[0] : '0;
        end
    end

    // Directed sequences with hand-computed expectations, then random traffic.
    initial begin
        rst          = 1'b1;
        wr_en        = 1'b0;
        wr_data      = '0;
        egress_ready = 1'b0;

        // Reset, then 10 idle cycles.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            checkOutput("idle_valid", {31'd0, egress_valid}, 32'd0);
            checkOutput("idle_level", {29'd0, level}, 32'd0);
            checkOutput("idle_full", {31'd0, full}, 32'd0);
            checkOutput("idle_drop", {16'd0, drop_cnt}, 32'd0);
        end

        // Fill with ready low, overflow once, then drain in order.
        applyStimulus(1'b0, 1'b1, 8'h11, 1'b0);
        checkOutput("first_valid", {31'd0, egress_valid}, 32'd1);
        checkOutput("first_data", {24'd0, egress_data}, 32'h11);
        applyStimulus(1'b0, 1'b1, 8'h22, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h44, 1'b0);
        checkOutput("fill_full", {31'd0, full}, 32'd1);
        checkOutput("fill_level", {29'd0, level}, 32'd4);
        checkOutput("fill_head", {24'd0, egress_data}, 32'h11);
        applyStimulus(1'b0, 1'b1, 8'h55, 1'b0);
        checkOutput("ovf_level", {29'd0, level}, 32'd4);
        checkOutput("ovf_head", {24'd0, egress_data}, 32'h11);
        checkOutput("ovf_drop", {16'd0, drop_cnt}, (DROP_ON != 0) ? 32'd1 : 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("drain1_data", {24'd0, egress_data}, 32'h22);
        checkOutput("drain1_level", {29'd0, level}, 32'd3);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("drain2_data", {24'd0, egress_data}, 32'h33);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("drain3_data", {24'd0, egress_data}, 32'h44);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("drained_valid", {31'd0, egress_valid}, 32'd0);
        checkOutput("drained_level", {29'd0, level}, 32'd0);

        // Back-to-back streaming with ready high. The pointers wrap many times.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 1'b1);
            checkOutput("stream_level", {29'd0, level}, 32'd1);
            checkOutput("stream_data", {24'd0, egress_data}, i);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("stream_end_level", {29'd0, level}, 32'd0);

        // When full, a push in the same cycle as a transfer is dropped.
        applyStimulus(1'b0, 1'b1, 8'hA1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hA2, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hA3, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hA4, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1);
        checkOutput("fullpop_level", {29'd0, level}, 32'd3);
        checkOutput("fullpop_full", {31'd0, full}, 32'd0);
        checkOutput("fullpop_head", {24'd0, egress_data}, 32'hA2);
        checkOutput("fullpop_drop", {16'd0, drop_cnt}, (DROP_ON != 0) ? 32'd2 : 32'd0);
        applyStimulus(1'b0, 1'b1, 8'hA6, 1'b0);
        checkOutput("refill_level", {29'd0, level}, 32'd4);
        checkOutput("refill_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        end
        checkOutput("refill_drained", {29'd0, level}, 32'd0);

        // Random pushes and random ready. The monitor checks order and
        // that a stalled head stays stable.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)));
        end
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        end
        checkOutput("random_drained", {29'd0, level}, 32'd0);

        // Reset with 2 words stored. The first push after reset becomes
        // the new head.
        applyStimulus(1'b0, 1'b1, 8'hB1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hB2, 1'b0);
        checkOutput("prerst_level", {29'd0, level}, 32'd2);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("rst_valid", {31'd0, egress_valid}, 32'd0);
        checkOutput("rst_level", {29'd0, level}, 32'd0);
        checkOutput("rst_drop", {16'd0, drop_cnt}, 32'd0);
        applyStimulus(1'b0, 1'b1, 8'hC3, 1'b0);
        checkOutput("postrst_valid", {31'd0, egress_valid}, 32'd1);
        checkOutput("postrst_head", {24'd0, egress_data}, 32'hC3);
        checkOutput("postrst_level", {29'd0, level}, 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("final_level", {29'd0, level}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_failed);
        $finish;
    end

endmodule
